// File: rtl/usb_rx_xfer_ctrl_if.sv
// usb_rx_xfer_ctrl_if
//   Bundles the signals between the device transaction controller and its
//   neighbours (RX packet FSM, TX encoder, host register block).
//
//   Handshake (controller <-> TX encoder): tx_start is a one-cycle request
//   with tx_packet valid in the same cycle; tx_packet then stays stable until
//   the encoder answers with a one-cycle tx_done pulse after the EOP.
//   The controller only listens for tx_done once it has left the start cycle.
//
//   modport master : the controller (usb_rx_xfer_ctrl)
//   modport slave  : the surrounding logic / testbench
//   state_dbg      : current controller state, for observation only
interface usb_rx_xfer_ctrl_if;
  logic [2:0] rx_packet;
  logic       tx_ready;
  logic       host_rx_ack;
  logic       host_err_clr;
  logic       stall_req;
  logic       tx_done;
  logic       tx_start;
  logic [2:0] tx_packet;
  logic       rx_buf_en;
  logic       clear_buffer;
  logic       d_mode;
  logic       rx_data_ready;
  logic       tx_data_sent;
  logic       error;
  logic [2:0] state_dbg;

  modport master (
    input  rx_packet, tx_ready, host_rx_ack, host_err_clr, stall_req, tx_done,
    output tx_start, tx_packet, rx_buf_en, clear_buffer, d_mode,
           rx_data_ready, tx_data_sent, error, state_dbg
  );

  modport slave (
    output rx_packet, tx_ready, host_rx_ack, host_err_clr, stall_req, tx_done,
    input  tx_start, tx_packet, rx_buf_en, clear_buffer, d_mode,
           rx_data_ready, tx_data_sent, error, state_dbg
  );
endinterface

// File: rtl/usb_rx_xfer_ctrl.sv
// usb_rx_xfer_ctrl
//   Device-side USB transaction controller. Turns RX packet codes into the
//   device response (ACK / NAK / DATA / STALL), gates RX buffer writes,
//   drives the TX encoder via tx_start/tx_done and enforces a handshake
//   timeout of TIMEOUT_CYCLES clocks.
//
//   Ports:
//     clk    rising-edge clock
//     n_rst  asynchronous active-low reset
//     bus    usb_rx_xfer_ctrl_if.master (all packet/handshake/host signals)
//
//   Optional feature: define USB_STALL_EN to honour stall_req (STALL replies
//   to IN, forced NAK for OUT). Without it stall_req is ignored.
module usb_rx_xfer_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               n_rst,
  usb_rx_xfer_ctrl_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] RX_DATA = 3'd1;
  localparam logic [2:0] RX_OUT  = 3'd2;
  localparam logic [2:0] RX_IN   = 3'd3;
  localparam logic [2:0] RX_ACK  = 3'd4;
  localparam logic [2:0] RX_BAD  = 3'd6;

  localparam logic [2:0] TX_NONE  = 3'd0;
  localparam logic [2:0] TX_DATA  = 3'd1;
  localparam logic [2:0] TX_ACK   = 3'd2;
  localparam logic [2:0] TX_NAK   = 3'd3;
  localparam logic [2:0] TX_STALL = 3'd4;

  typedef enum logic [2:0] {
    IDLE, OUT_WAIT, HS_START, HS_BUSY, IN_START, IN_BUSY, IN_WAIT_ACK
  } state_t;

  state_t        state, next_state;
  logic [2:0]    rx_prev;
  logic          nak_pending, nak_pending_n;
  logic [TW-1:0] timer;
  logic [2:0]    tx_packet_r, tx_packet_n;
  logic          rx_data_ready_r, error_r, clear_buffer_r, tx_data_sent_r;
  logic          set_rdy, set_err, clr_buf, data_sent;
  logic          stall, evt, in_wait, timeout;

`ifdef USB_STALL_EN
  assign stall = bus.stall_req;
`else
  logic unused_stall_req;
  assign unused_stall_req = bus.stall_req;
  assign stall = 1'b0;
`endif

  // A packet code counts once: only when it is non-idle and differs from
  // the previous cycle's code.
  assign evt     = (bus.rx_packet != 3'd0) && (bus.rx_packet != rx_prev);
  assign in_wait = (state == OUT_WAIT) || (state == IN_WAIT_ACK);
  assign timeout = in_wait && (timer == T_LAST);

  always_comb begin
    next_state    = state;
    tx_packet_n   = tx_packet_r;
    nak_pending_n = nak_pending;
    set_rdy       = 1'b0;
    set_err       = 1'b0;
    clr_buf       = 1'b0;
    data_sent     = 1'b0;
    case (state)
      IDLE: begin
        if (evt) begin
          if (bus.rx_packet == RX_OUT) begin
            next_state    = OUT_WAIT;
            nak_pending_n = rx_data_ready_r | stall;
          end else if (bus.rx_packet == RX_IN) begin
            if (stall) begin
              next_state  = HS_START;
              tx_packet_n = TX_STALL;
            end else if (bus.tx_ready) begin
              next_state  = IN_START;
              tx_packet_n = TX_DATA;
            end else begin
              next_state  = HS_START;
              tx_packet_n = TX_NAK;
            end
          end else if (bus.rx_packet == RX_BAD) begin
            set_err = 1'b1;
          end
        end
      end
      OUT_WAIT: begin
        if (evt && bus.rx_packet == RX_DATA) begin
          next_state  = HS_START;
          tx_packet_n = nak_pending ? TX_NAK : TX_ACK;
          set_rdy     = !nak_pending;
        end else if ((evt && (bus.rx_packet == RX_BAD || bus.rx_packet == RX_OUT ||
                              bus.rx_packet == RX_IN)) || timeout) begin
          // Buffer only holds partial data if we were accepting it.
          next_state = IDLE;
          set_err    = 1'b1;
          clr_buf    = !nak_pending;
        end
      end
      HS_START: next_state = HS_BUSY;
      HS_BUSY:  if (bus.tx_done) next_state = IDLE;
      IN_START: next_state = IN_BUSY;
      IN_BUSY:  if (bus.tx_done) next_state = IN_WAIT_ACK;
      IN_WAIT_ACK: begin
        if (evt) begin
          next_state = IDLE;
          if (bus.rx_packet == RX_ACK) data_sent = 1'b1;
          else                         set_err   = 1'b1;
        end else if (timeout) begin
          next_state = IDLE;
          set_err    = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    if (next_state == IDLE) tx_packet_n = TX_NONE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state           <= IDLE;
      rx_prev         <= 3'd0;
      nak_pending     <= 1'b0;
      timer           <= '0;
      tx_packet_r     <= TX_NONE;
      rx_data_ready_r <= 1'b0;
      error_r         <= 1'b0;
      clear_buffer_r  <= 1'b0;
      tx_data_sent_r  <= 1'b0;
    end else begin
      state          <= next_state;
      rx_prev        <= bus.rx_packet;
      nak_pending    <= nak_pending_n;
      // Wait states are only entered from non-wait states, so the timer is
      // always zero on entry; the state exits on timeout, so no wrap.
      timer          <= in_wait ? timer + 1'b1 : '0;
      tx_packet_r    <= tx_packet_n;
      clear_buffer_r <= clr_buf;
      tx_data_sent_r <= data_sent;
      if (set_rdy)              rx_data_ready_r <= 1'b1;
      else if (bus.host_rx_ack) rx_data_ready_r <= 1'b0;
      if (set_err)               error_r <= 1'b1;
      else if (bus.host_err_clr) error_r <= 1'b0;
    end
  end

  assign bus.tx_start      = (state == HS_START) || (state == IN_START);
  assign bus.tx_packet     = tx_packet_r;
  assign bus.rx_buf_en     = (state == OUT_WAIT) && !nak_pending;
  assign bus.clear_buffer  = clear_buffer_r;
  assign bus.d_mode        = (state == HS_START) || (state == HS_BUSY) ||
                             (state == IN_START) || (state == IN_BUSY);
  assign bus.rx_data_ready = rx_data_ready_r;
  assign bus.tx_data_sent  = tx_data_sent_r;
  assign bus.error         = error_r;
  assign bus.state_dbg     = state;
endmodule

// File: doc/usb_rx_xfer_ctrl.md
# usb_rx_xfer_ctrl

Device-side transaction controller for the USB CDL. Consumes the 3-bit packet codes reported by the RX control FSM, decides the device's response to each OUT/IN token (ACK, NAK, DATA, STALL), gates RX buffer writes, sequences the TX encoder through a start/done handshake, and enforces a handshake timeout. Sits between the RX/TX packet FSMs and the AHB-facing host registers.

## Interface
- TIMEOUT_CYCLES, 1024: clk cycles allowed between OUT token and DATA packet, and between end of transmitted DATA and the host's ACK.
- clk  in  1  clock, rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- rx_packet  in  3  RX packet code: 0 idle, 1 data-good, 2 OUT, 3 IN, 4 ACK, 5 NAK, 6 bad, 7 stall.
- tx_ready  in  1  level; host has loaded IN data into the buffer.
- host_rx_ack  in  1  pulse; host has drained received OUT data.
- host_err_clr  in  1  pulse; clears `error`.
- stall_req  in  1  level; endpoint halted (used only with USB_STALL_EN).
- tx_done  in  1  pulse from TX encoder: requested packet fully sent, including EOP.
- tx_start  out  1  one-cycle request to the TX encoder.
- tx_packet  out  3  TX code: 0 none, 1 DATA, 2 ACK, 3 NAK, 4 STALL.
- rx_buf_en  out  1  enables RX writes into the shared data buffer.
- clear_buffer  out  1  one-cycle pulse; discard the buffer contents.
- d_mode  out  1  1 while device owns the bus (TX path selected).
- rx_data_ready  out  1  sticky; valid OUT data in buffer.
- tx_data_sent  out  1  one-cycle pulse; IN data ACKed by host.
- error  out  1  sticky protocol error flag.

## Operation
- Event detect: `rx_prev` register (reset 0). An event occurs in any cycle where rx_packet != 0 and rx_packet != rx_prev. All decisions use events only.
- States: IDLE, OUT_WAIT, HS_START, HS_BUSY, IN_START, IN_BUSY, IN_WAIT_ACK.
- IDLE, OUT event -> OUT_WAIT. Latch nak_pending = rx_data_ready | stall.
- IDLE, IN event: stall -> HS_START(STALL); else tx_ready -> IN_START; else HS_START(NAK).
- IDLE, bad event -> set error. Other events are ignored.
- OUT_WAIT: data event -> HS_START(NAK) if nak_pending, else HS_START(ACK) and set rx_data_ready. Bad event, any token event, or timeout -> set error, pulse clear_buffer if !nak_pending, -> IDLE.
- HS_START: tx_start=1, -> HS_BUSY. HS_BUSY: tx_done -> IDLE.
- IN_START: tx_start=1, tx_packet=DATA, -> IN_BUSY. IN_BUSY: tx_done -> IN_WAIT_ACK.
- IN_WAIT_ACK: ACK event -> pulse tx_data_sent, -> IDLE. Any other event or timeout -> set error, -> IDLE. Buffer is kept for host retry.
- rx_buf_en = 1 only in OUT_WAIT with nak_pending=0.
- d_mode = 1 in HS_START, HS_BUSY, IN_START, IN_BUSY.
- Timer: cleared on entry to OUT_WAIT/IN_WAIT_ACK; increments each cycle in those states. Timeout fires when count == TIMEOUT_CYCLES-1. Width is $clog2(TIMEOUT_CYCLES); no wrap occurs because the state exits on timeout.
- rx_data_ready cleared by host_rx_ack. If a set and a clear occur in the same cycle, set wins. Clearing during OUT_WAIT does not alter the latched nak_pending.
- error cleared by host_err_clr. If a set and a clear occur in the same cycle, set wins.

## Timing
- Reset values: state IDLE, all outputs 0, tx_packet 0, timer 0, rx_prev 0, nak_pending 0.
- Event in cycle N -> state update at edge ending N. tx_start is high for exactly cycle N+1, with tx_packet valid in the same cycle.
- tx_packet is registered when the state machine leaves IDLE/OUT_WAIT/IN_BUSY, held until return to IDLE, then 0.
- clear_buffer, error set and rx_data_ready set are registered: visible in the cycle after the causing event.
- tx_done while not in HS_BUSY/IN_BUSY is ignored. tx_done in the same cycle as tx_start is ignored (tx_done is sampled from the BUSY state only).
- Reset mid-transaction returns to IDLE asynchronously. No tx_start is issued after n_rst deasserts until a new event.

## Configuration
- USB_STALL_EN defined: stall = stall_req, enabling STALL responses and OUT NAK forcing.
- USB_STALL_EN undefined: stall = 0, stall_req is ignored, and tx_packet never equals 4.

## Test plan
- OUT(2), 10 cycles later data(1), rx_data_ready=0 -> rx_buf_en high in between; tx_start with tx_packet=2 one cycle after data; rx_data_ready=1; tx_done -> IDLE, d_mode=0.
- OUT then data with rx_data_ready=1 -> rx_buf_en stays 0, tx_packet=3 (NAK), rx_data_ready stays 1; host_rx_ack then clears it.
- IN(3) with tx_ready=1 -> tx_packet=1; tx_done; ACK(4) 50 cycles later -> single tx_data_sent pulse, error=0.
- IN with tx_ready=1, tx_done, no ACK -> error=1 exactly TIMEOUT_CYCLES cycles after IN_WAIT_ACK entry; host_err_clr -> 0.
- OUT, then bad(6) -> error=1, one clear_buffer pulse, no tx_start.
- With USB_STALL_EN and stall_req=1: IN -> tx_packet=4. Without USB_STALL_EN, same stimulus -> NAK (3) or DATA (1) per tx_ready.
